pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the dual-issue pipeline. Merges stall requests from IF, ID,
//  EXE (multi-cycle divide) and MEM into the STALL_BUS vector driven to every stage register.

---
 rtl/pipe_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: merges stage stall requests into the stall vector, drives flush/redirect,
// runs the multi-cycle divide wait FSM and a saturating stall-cycle counter. 0-cycle outputs.
module pipe_stall_ctrl #(
    parameter int          STALL_W    = 6,
    parameter int          DIV_CYCLES = 34,
    parameter logic [31:0] EXC_ENTRY  = 32'hBFC00380,
    parameter int          PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_mem,
    input  logic              div_start,
    input  logic              exc_req,
    input  logic              exc_is_eret,
    input  logic [31:0]       cp0_epc,
    input  logic              perf_clr,
    output logic [STALL_W-1:0] stall,
    output logic              flush,
    output logic [31:0]       flush_pc,
    output logic              div_busy,
    output logic              div_ready,
    output logic              div_cancel,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [5:0]         DIV_INIT   = 6'(DIV_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
    localparam logic [STALL_W-1:0] STALL_EXE  = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_IF   = STALL_W'(6'b000011);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       ready_c, cancel_c, stall_exe;
    logic [STALL_W-1:0] stall_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_c   = 1'b0;
        cancel_c  = 1'b0;
        case (state)
            IDLE: begin
                if (div_start && !exc_req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = DIV_INIT;
                end
            end
            WAIT: begin
                // A flush kills the divide even on its final cycle; no result is delivered.
                if (exc_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    cancel_c  = 1'b1;
                end else if (cnt != 6'd0) begin
                    cnt_nxt = cnt - 6'd1;
                end else begin
                    state_nxt = IDLE;
                    ready_c   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_exe = ((state == IDLE) && div_start) || ((state == WAIT) && (cnt != 6'd0));

    always_comb begin
        stall_c = '0;
        if (exc_req)           stall_c = '0;
        else if (stallreq_mem) stall_c = STALL_MEM;
        else if (stall_exe)    stall_c = STALL_EXE;
        else if (stallreq_id)  stall_c = STALL_ID;
        else if (stallreq_if)  stall_c = STALL_IF;
    end

    // Outputs are forced low for the whole reset assertion, not only after the edge.
    always_comb begin
        stall      = '0;
        flush      = 1'b0;
        flush_pc   = '0;
        div_busy   = 1'b0;
        div_ready  = 1'b0;
        div_cancel = 1'b0;
        if (!rst) begin
            stall      = stall_c;
            flush      = exc_req;
            flush_pc   = exc_req ? (exc_is_eret ? cp0_epc : EXC_ENTRY) : 32'd0;
            div_busy   = (state == WAIT);
            div_ready  = ready_c;
            div_cancel = cancel_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
        end else if ((stall_c != '0) && (perf_stall_cnt != {PERF_W{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_pipe_stall_ctrl;

    localparam int          DIVC = 34;
    localparam logic [31:0] EXC  = 32'hBFC00380;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic        ready;
        logic        cancel;
        logic [31:0] perf;
        logic [3:0]  perf4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 0, stallreq_id = 0, stallreq_mem = 0;
    logic        div_start = 0, exc_req = 0, exc_is_eret = 0, perf_clr = 0;
    logic [31:0] cp0_epc = '0;

    logic [5:0]  stall, stall4;
    logic        flush, flush4, div_busy, busy4, div_ready, ready4, div_cancel, cancel4;
    logic [31:0] flush_pc, pc4, perf_stall_cnt;
    logic [3:0]  perf4;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_mem(stallreq_mem), .div_start(div_start), .exc_req(exc_req),
        .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc), .perf_clr(perf_clr),
        .stall(stall), .flush(flush), .flush_pc(flush_pc), .div_busy(div_busy),
        .div_ready(div_ready), .div_cancel(div_cancel), .perf_stall_cnt(perf_stall_cnt)
    );

    pipe_stall_ctrl #(.PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_mem(stallreq_mem), .div_start(div_start), .exc_req(exc_req),
        .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc), .perf_clr(perf_clr),
        .stall(stall4), .flush(flush4), .flush_pc(pc4), .div_busy(busy4),
        .div_ready(ready4), .div_cancel(cancel4), .perf_stall_cnt(perf4)
    );

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference state: cycles left until the result cycle (0 = idle), and counters.
    int          mdl_left = 0;
    logic [31:0] mdl_perf = '0;
    logic [3:0]  mdl_perf4 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic i_if, input logic i_id, input logic i_mem,
                       input logic i_div, input logic i_exc, input logic i_eret,
                       input logic [31:0] epc, input logic clr);
        exp_t e;
        exp_t o;
        logic exe;
        @(posedge clk);
        #1;
        rst = r; stallreq_if = i_if; stallreq_id = i_id; stallreq_mem = i_mem;
        div_start = i_div; exc_req = i_exc; exc_is_eret = i_eret; cp0_epc = epc; perf_clr = clr;
        e = '0;
        if (!r) begin
            exe      = (mdl_left == 0 && i_div) || (mdl_left > 1);
            e.flush  = i_exc;
            e.pc     = i_exc ? (i_eret ? epc : EXC) : 32'd0;
            e.busy   = (mdl_left > 0);
            e.ready  = (mdl_left == 1) && !i_exc;
            e.cancel = (mdl_left > 0) && i_exc;
            e.stall  = i_exc ? 6'h00 : i_mem ? 6'h1F : exe ? 6'h0F : i_id ? 6'h07 : i_if ? 6'h03 : 6'h00;
            e.perf   = mdl_perf;
            e.perf4  = mdl_perf4;
        end
        sb_q.push_back(e);
        // Advance the reference to the state after the coming edge.
        if (r) begin
            mdl_left = 0; mdl_perf = '0; mdl_perf4 = '0;
        end else begin
            if (mdl_left == 0) mdl_left = (i_div && !i_exc) ? DIVC : 0;
            else               mdl_left = i_exc ? 0 : mdl_left - 1;
            if (clr) begin
                mdl_perf = '0; mdl_perf4 = '0;
            end else if (e.stall != 0) begin
                if (mdl_perf != 32'hFFFF_FFFF) mdl_perf++;
                if (mdl_perf4 != 4'hF) mdl_perf4++;
            end
        end
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            o = sb_q.pop_front();
            chk("stall", {58'd0, stall}, {58'd0, o.stall});
            chk("flush", {63'd0, flush}, {63'd0, o.flush});
            chk("flush_pc", {32'd0, flush_pc}, {32'd0, o.pc});
            chk("div_busy", {63'd0, div_busy}, {63'd0, o.busy});
            chk("div_ready", {63'd0, div_ready}, {63'd0, o.ready});
            chk("div_cancel", {63'd0, div_cancel}, {63'd0, o.cancel});
            chk("perf", {32'd0, perf_stall_cnt}, {32'd0, o.perf});
            chk("perf4", {60'd0, perf4}, {60'd0, o.perf4});
        end
    endtask

    task automatic idle(input logic i_mem);
        cyc(0, 0, 0, i_mem, 0, 0, 0, 32'd0, 0);
    endtask

    initial begin
        int n_st, rdy_at, n_busy, n_rdy;

        // Reset with every request asserted: outputs must stay low.
        cyc(1, 1, 1, 1, 1, 1, 1, 32'h1111_2222, 0);
        cyc(1, 1, 1, 1, 1, 1, 0, 32'h0, 0);
        idle(0);

        // Single divide: stall count, ready position and busy window.
        n_st = 0; rdy_at = 0; n_busy = 0;
        for (int k = 1; k <= 37; k++) begin
            cyc(0, 0, 0, 0, (k == 1), 0, 0, 32'd0, 0);
            if (stall == 6'h0F) n_st++;
            if (div_ready) rdy_at = k;
            if (div_busy) n_busy++;
        end
        chk("div_stall_cycles", 64'(n_st), 64'd34);
        chk("div_ready_cycle", 64'(rdy_at), 64'd35);
        chk("div_busy_cycles", 64'(n_busy), 64'd34);

        // Requester priority.
        cyc(0, 1, 0, 0, 0, 0, 0, 32'd0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 32'd0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 32'd0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 32'd0, 0);

        // Exception at cnt=20 during a divide.
        cyc(0, 0, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int k = 0; k < 100 && mdl_left != 21; k++) idle(0);
        cyc(0, 1, 1, 1, 1, 1, 0, 32'hDEAD_BEEF, 0);
        chk("exc_pc_direct", {32'd0, flush_pc}, {32'd0, EXC});
        idle(0);
        idle(0);

        // ERET with data-bus stall pending.
        cyc(0, 0, 0, 1, 0, 1, 1, 32'h8000_1234, 0);
        chk("eret_pc_direct", {32'd0, flush_pc}, 64'h8000_1234);

        // div_start together with exception in IDLE: ignored.
        cyc(0, 0, 0, 0, 1, 1, 0, 32'd0, 0);
        idle(0);

        // Divide under a continuous data-bus stall, ready coincides with it; div_start in WAIT ignored.
        cyc(0, 0, 0, 1, 1, 0, 0, 32'd0, 0);
        n_rdy = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(0, 0, 0, 1, (k == 5), 0, 0, 32'd0, 0);
            if (div_ready) n_rdy++;
        end
        chk("ready_under_mem", 64'(n_rdy), 64'd1);

        // Reset asserted mid-divide at cnt=10.
        cyc(0, 0, 0, 0, 1, 0, 0, 32'd0, 0);
        for (int k = 0; k < 100 && mdl_left != 11; k++) idle(0);
        cyc(1, 1, 1, 1, 1, 1, 0, 32'd0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
        n_rdy = 0; n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            idle(0);
            if (div_ready) n_rdy++;
            if (div_busy) n_busy++;
        end
        chk("rst_no_ready", 64'(n_rdy), 64'd0);
        chk("rst_no_busy", 64'(n_busy), 64'd0);

        // Counter saturation on the 4-bit instance, then clear.
        cyc(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0, 0, 0, 32'd0, 0);
        idle(0);
        chk("perf4_sat", {60'd0, perf4}, 64'hF);
        chk("perf_20", {32'd0, perf_stall_cnt}, 64'd20);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'd0, 1);
        idle(0);
        chk("perf4_clr", {60'd0, perf4}, 64'd0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
